// File: rtl/axi_split_pkg.sv
// Shared encodings, FSM state codes and response helper for the AXI burst splitter.
// The wrap feature is controlled by AXI_SPLIT_WRAP_EN in axi_split_addr_gen.
package axi_split_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [1:0] rd_state_t;
    localparam rd_state_t R_IDLE = 2'd0;
    localparam rd_state_t R_ADDR = 2'd1;
    localparam rd_state_t R_WAIT = 2'd2;
    localparam rd_state_t R_RESP = 2'd3;

    typedef logic [1:0] wr_state_t;
    localparam wr_state_t W_IDLE  = 2'd0;
    localparam wr_state_t W_DATA  = 2'd1;
    localparam wr_state_t W_BWAIT = 2'd2;
    localparam wr_state_t W_RESP  = 2'd3;

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_split_if.sv
// AXI4 link bundle (AR/R/AW/W/B) used on both sides of the burst splitter.
// master drives addresses, write data and response readies; slave the rest.
interface axi_burst_split_if #(parameter int TAGW = 1);

    logic            arvalid, arready;
    logic [31:0]     araddr;
    logic [TAGW-1:0] arid;
    logic [7:0]      arlen;
    logic [1:0]      arburst;
    logic [2:0]      arsize;

    logic            rvalid, rready;
    logic [63:0]     rdata;
    logic [1:0]      rresp;
    logic [TAGW-1:0] rid;
    logic            rlast;

    logic            awvalid, awready;
    logic [31:0]     awaddr;
    logic [TAGW-1:0] awid;
    logic [7:0]      awlen;
    logic [1:0]      awburst;
    logic [2:0]      awsize;

    logic            wvalid, wready;
    logic [63:0]     wdata;
    logic [7:0]      wstrb;
    logic            wlast;

    logic            bvalid, bready;
    logic [1:0]      bresp;
    logic [TAGW-1:0] bid;

    modport master (
        output arvalid, araddr, arid, arlen, arburst, arsize,
        input  arready,
        input  rvalid, rdata, rresp, rid, rlast,
        output rready,
        output awvalid, awaddr, awid, awlen, awburst, awsize,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arburst, arsize,
        output arready,
        output rvalid, rdata, rresp, rid, rlast,
        input  rready,
        input  awvalid, awaddr, awid, awlen, awburst, awsize,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );

endinterface

// File: rtl/axi_split_addr_gen.sv
// Next-beat address for FIXED/INCR bursts; WRAP support when AXI_SPLIT_WRAP_EN is defined.
// err_o flags an illegal wrap length (only possible with the wrap feature built in).
module axi_split_addr_gen
    import axi_split_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [7:0]  len_i,
    input  logic [2:0]  size_i,
    input  logic [1:0]  burst_i,
    output logic [31:0] next_o,
    output logic        err_o
);

    logic [31:0] step;
    logic [31:0] incr;

    assign step = 32'd1 << size_i;
    assign incr = addr_i + step;

`ifdef AXI_SPLIT_WRAP_EN
    logic [31:0] mask;
    logic        legal;

    assign mask = (({24'd0, len_i} + 32'd1) * step) - 32'd1;

    always_comb begin
        case (len_i)
            8'd1, 8'd3, 8'd7, 8'd15: legal = 1'b1;
            default:                 legal = 1'b0;
        endcase
    end

    always_comb begin
        next_o = incr;
        err_o  = 1'b0;
        if (burst_i == BURST_FIXED) begin
            next_o = addr_i;
        end else if (burst_i == BURST_WRAP) begin
            next_o = (addr_i & ~mask) | (incr & mask);
            err_o  = !legal;
        end
    end
`else
    assign next_o = (burst_i == BURST_FIXED) ? addr_i : incr;
    assign err_o  = 1'b0;
`endif

endmodule

// File: rtl/axi_burst_split.sv
// Splits AXI4 AR/AW bursts into single-beat transfers and rebuilds one burst response.
// Optional WRAP handling is enabled by defining AXI_SPLIT_WRAP_EN.
module axi_burst_split
    import axi_split_pkg::*;
#(
    parameter int TAGW = 1
) (
    input  logic              aclk,
    input  logic              rst_l,
    axi_burst_split_if.slave  s_axi,
    axi_burst_split_if.master m_axi
);

    rd_state_t       rs_q, rs_d;
    logic            arready_q;
    logic [31:0]     raddr_q, raddr_nx;
    logic [TAGW-1:0] rid_q;
    logic [7:0]      rlen_q, rbeat_q;
    logic [1:0]      rburst_q, rresp_q;
    logic [2:0]      rsize_q;
    logic [63:0]     rdata_q;
    logic            r_last, r_err, ar_hs;

    wr_state_t       ws_q, ws_d;
    logic            awready_q;
    logic [31:0]     waddr_q, waddr_nx;
    logic [TAGW-1:0] wid_q;
    logic [7:0]      wlen_q, wbeat_q;
    logic [1:0]      wburst_q, wacc_q;
    logic [2:0]      wsize_q;
    logic            w_last, w_err, aw_hs, w_hs, b_hs, w_step;

    axi_split_addr_gen u_rd_gen (
        .addr_i(raddr_q), .len_i(rlen_q), .size_i(rsize_q),
        .burst_i(rburst_q), .next_o(raddr_nx), .err_o(r_err)
    );

    axi_split_addr_gen u_wr_gen (
        .addr_i(waddr_q), .len_i(wlen_q), .size_i(wsize_q),
        .burst_i(wburst_q), .next_o(waddr_nx), .err_o(w_err)
    );

    assign r_last = (rbeat_q == rlen_q);
    assign ar_hs  = (rs_q == R_IDLE) && arready_q && s_axi.arvalid;

    always_comb begin
        rs_d = rs_q;
        unique case (rs_q)
            R_IDLE: if (ar_hs) rs_d = R_ADDR;
            R_ADDR: begin
                if (r_err) rs_d = R_RESP;
                else if (m_axi.arready) rs_d = R_WAIT;
            end
            R_WAIT: if (m_axi.rvalid) rs_d = R_RESP;
            R_RESP: if (s_axi.rready) rs_d = r_last ? R_IDLE : R_ADDR;
            default: rs_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!rst_l) begin
            rs_q      <= R_IDLE;
            arready_q <= 1'b0;
            raddr_q   <= '0;
            rid_q     <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rburst_q  <= '0;
            rsize_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            rs_q      <= rs_d;
            arready_q <= (rs_q == R_IDLE) && s_axi.arvalid && !arready_q;
            if (ar_hs) begin
                raddr_q  <= s_axi.araddr;
                rid_q    <= s_axi.arid;
                rlen_q   <= s_axi.arlen;
                rburst_q <= s_axi.arburst;
                rsize_q  <= s_axi.arsize;
                rbeat_q  <= '0;
            end
            // Illegal wrap: answer locally without touching the slave.
            if (rs_q == R_ADDR && r_err) begin
                rdata_q <= '0;
                rresp_q <= RESP_SLVERR;
            end
            if (rs_q == R_WAIT && m_axi.rvalid) begin
                rdata_q <= m_axi.rdata;
                rresp_q <= m_axi.rresp;
            end
            if (rs_q == R_RESP && s_axi.rready && !r_last) begin
                rbeat_q <= rbeat_q + 8'd1;
                raddr_q <= raddr_nx;
            end
        end
    end

    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = (rs_q == R_RESP);
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rid     = rid_q;
    assign s_axi.rlast   = r_last;

    assign m_axi.arvalid = (rs_q == R_ADDR) && !r_err;
    assign m_axi.araddr  = raddr_q;
    assign m_axi.arid    = rid_q;
    assign m_axi.arlen   = 8'd0;
    assign m_axi.arburst = BURST_INCR;
    assign m_axi.arsize  = rsize_q;
    assign m_axi.rready  = (rs_q == R_WAIT);

    assign w_last = (wbeat_q == wlen_q);
    assign aw_hs  = (ws_q == W_IDLE) && awready_q && s_axi.awvalid;
    assign w_hs   = s_axi.wvalid && s_axi.wready;
    assign b_hs   = (ws_q == W_BWAIT) && m_axi.bvalid;
    assign w_step = ((w_hs && w_err) || b_hs) && !w_last;

    always_comb begin
        ws_d = ws_q;
        unique case (ws_q)
            W_IDLE:  if (aw_hs) ws_d = W_DATA;
            W_DATA: begin
                if (w_hs && !w_err) ws_d = W_BWAIT;
                else if (w_hs) ws_d = w_last ? W_RESP : W_DATA;
            end
            W_BWAIT: if (m_axi.bvalid) ws_d = w_last ? W_RESP : W_DATA;
            W_RESP:  if (s_axi.bready) ws_d = W_IDLE;
            default: ws_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!rst_l) begin
            ws_q      <= W_IDLE;
            awready_q <= 1'b0;
            waddr_q   <= '0;
            wid_q     <= '0;
            wlen_q    <= '0;
            wbeat_q   <= '0;
            wburst_q  <= '0;
            wsize_q   <= '0;
            wacc_q    <= '0;
        end else begin
            ws_q      <= ws_d;
            awready_q <= (ws_q == W_IDLE) && s_axi.awvalid && !awready_q;
            if (aw_hs) begin
                waddr_q  <= s_axi.awaddr;
                wid_q    <= s_axi.awid;
                wlen_q   <= s_axi.awlen;
                wburst_q <= s_axi.awburst;
                wsize_q  <= s_axi.awsize;
                wbeat_q  <= '0;
                wacc_q   <= RESP_OKAY;
            end
            // Beat count is authoritative; a wlast disagreement poisons the response.
            if (w_hs && (w_err || (s_axi.wlast != w_last)))
                wacc_q <= resp_max(wacc_q, RESP_SLVERR);
            if (b_hs)
                wacc_q <= resp_max(wacc_q, m_axi.bresp);
            if (w_step) begin
                wbeat_q <= wbeat_q + 8'd1;
                waddr_q <= waddr_nx;
            end
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = (ws_q == W_DATA)
                         && (w_err || (m_axi.awready && m_axi.wready));
    assign s_axi.bvalid  = (ws_q == W_RESP);
    assign s_axi.bresp   = wacc_q;
    assign s_axi.bid     = wid_q;

    assign m_axi.awvalid = (ws_q == W_DATA) && s_axi.wvalid && !w_err;
    assign m_axi.awaddr  = waddr_q;
    assign m_axi.awid    = wid_q;
    assign m_axi.awlen   = 8'd0;
    assign m_axi.awburst = BURST_INCR;
    assign m_axi.awsize  = wsize_q;
    assign m_axi.wvalid  = (ws_q == W_DATA) && s_axi.wvalid && !w_err;
    assign m_axi.wdata   = s_axi.wdata;
    assign m_axi.wstrb   = s_axi.wstrb;
    assign m_axi.wlast   = 1'b1;
    assign m_axi.bready  = (ws_q == W_BWAIT);

endmodule

// File: tb/tb_axi_burst_split.sv
// Directed bench for axi_burst_split with a single-beat slave model downstream.
// Define AXI_SPLIT_WRAP_EN for both RTL and bench to exercise WRAP bursts.
module tb_axi_burst_split;
    import axi_split_pkg::*;

    localparam int TAGW = 1;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    axi_burst_split_if #(.TAGW(TAGW)) s_if ();
    axi_burst_split_if #(.TAGW(TAGW)) m_if ();

    axi_burst_split #(.TAGW(TAGW)) dut (
        .aclk(clk), .rst_l(rst_l), .s_axi(s_if), .m_axi(m_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic        slv_rv = 1'b0, slv_bv = 1'b0, inj_rv = 1'b0;
    logic [63:0] slv_rd = '0;
    logic [1:0]  slv_br = '0;
    int          ar_bad = 0;

    logic [31:0] ar_log[$], aw_log[$];
    logic [63:0] w_log[$];
    logic [7:0]  ws_log[$];
    logic [1:0]  br_cfg[$];

    logic [63:0]     r_data[$];
    logic            r_last[$];
    logic [TAGW-1:0] r_id[$];
    logic [1:0]      r_resp[$];
    logic [1:0]      b_resp[$];
    logic [TAGW-1:0] b_id[$];

    logic [31:0] exp_ra[$], exp_wa[$];

    assign m_if.arready = 1'b1;
    assign m_if.awready = 1'b1;
    assign m_if.wready  = 1'b1;
    assign m_if.rvalid  = slv_rv | inj_rv;
    assign m_if.rdata   = slv_rd;
    assign m_if.rresp   = RESP_OKAY;
    assign m_if.rid     = '0;
    assign m_if.rlast   = 1'b1;
    assign m_if.bvalid  = slv_bv;
    assign m_if.bresp   = slv_br;
    assign m_if.bid     = '0;

    // Single-beat slave: answers one cycle after each accepted request.
    always @(posedge clk) begin
        slv_rv <= 1'b0;
        slv_bv <= 1'b0;
        if (m_if.arvalid && m_if.arready) begin
            ar_log.push_back(m_if.araddr);
            if (m_if.arlen != 8'd0 || m_if.arburst != BURST_INCR)
                ar_bad <= ar_bad + 1;
            slv_rv <= 1'b1;
            slv_rd <= {~m_if.araddr, m_if.araddr};
        end
        if (m_if.awvalid && m_if.awready && m_if.wvalid && m_if.wready) begin
            aw_log.push_back(m_if.awaddr);
            w_log.push_back(m_if.wdata);
            ws_log.push_back(m_if.wstrb);
            if (m_if.awlen != 8'd0 || m_if.awburst != BURST_INCR)
                ar_bad <= ar_bad + 1;
            slv_bv <= 1'b1;
            slv_br <= (br_cfg.size() > 0) ? br_cfg.pop_front() : RESP_OKAY;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd_burst(input logic [31:0] a, input logic [TAGW-1:0] id,
                            input logic [7:0] len, input logic [1:0] bu,
                            input logic [2:0] sz, input int stall,
                            input logic [63:0] sexp);
        int t;
        s_if.arvalid = 1'b1;
        s_if.araddr  = a;
        s_if.arid    = id;
        s_if.arlen   = len;
        s_if.arburst = bu;
        s_if.arsize  = sz;
        t = 0;
        while (!s_if.arready && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) begin
            check("ar_tmo", 64'(t), 64'd0);
            s_if.arvalid = 1'b0;
            return;
        end
        @(negedge clk);
        s_if.arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            t = 0;
            while (!s_if.rvalid && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) begin
                check("r_tmo", 64'(t), 64'd0);
                return;
            end
            if (b == 0 && stall > 0) begin
                s_if.rready = 1'b0;
                for (int k = 0; k < stall; k++) begin
                    check("r_stall_v", 64'(s_if.rvalid), 64'd1);
                    check("r_stall_d", s_if.rdata, sexp);
                    @(negedge clk);
                end
                s_if.rready = 1'b1;
            end
            r_data.push_back(s_if.rdata);
            r_last.push_back(s_if.rlast);
            r_id.push_back(s_if.rid);
            r_resp.push_back(s_if.rresp);
            @(negedge clk);
        end
    endtask

    task automatic wr_burst(input logic [31:0] a, input logic [TAGW-1:0] id,
                            input logic [7:0] len, input logic [1:0] bu,
                            input logic [2:0] sz, input int bad_last,
                            input logic [63:0] wbase);
        int t;
        s_if.awvalid = 1'b1;
        s_if.awaddr  = a;
        s_if.awid    = id;
        s_if.awlen   = len;
        s_if.awburst = bu;
        s_if.awsize  = sz;
        t = 0;
        while (!s_if.awready && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) begin
            check("aw_tmo", 64'(t), 64'd0);
            s_if.awvalid = 1'b0;
            return;
        end
        @(negedge clk);
        s_if.awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            s_if.wvalid = 1'b1;
            s_if.wdata  = wbase + 64'(b);
            s_if.wstrb  = 8'hFF ^ 8'(b);
            s_if.wlast  = (b == int'(len)) ^ (b == bad_last);
            t = 0;
            while (!s_if.wready && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) begin
                check("w_tmo", 64'(t), 64'd0);
                s_if.wvalid = 1'b0;
                return;
            end
            @(negedge clk);
            s_if.wvalid = 1'b0;
        end
        t = 0;
        while (!s_if.bvalid && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin
            check("b_tmo", 64'(t), 64'd0);
            return;
        end
        b_resp.push_back(s_if.bresp);
        b_id.push_back(s_if.bid);
        @(negedge clk);
    endtask

    task automatic exp_rd(input string tag, input logic [TAGW-1:0] eid);
        int n;
        n = exp_ra.size();
        check({tag, "_nbeat"}, 64'(r_data.size()), 64'(n));
        check({tag, "_nar"}, 64'(ar_log.size()), 64'(n));
        foreach (exp_ra[i]) begin
            if (i < ar_log.size())
                check({tag, "_addr"}, 64'(ar_log[i]), 64'(exp_ra[i]));
            if (i < r_data.size()) begin
                check({tag, "_data"}, r_data[i], {~exp_ra[i], exp_ra[i]});
                check({tag, "_last"}, 64'(r_last[i]), 64'(i == n - 1));
                check({tag, "_id"}, 64'(r_id[i]), 64'(eid));
                check({tag, "_resp"}, 64'(r_resp[i]), 64'(RESP_OKAY));
            end
        end
        ar_log.delete(); r_data.delete(); r_last.delete();
        r_id.delete(); r_resp.delete(); exp_ra.delete();
    endtask

    task automatic exp_wr(input string tag, input logic [TAGW-1:0] eid,
                          input logic [1:0] eresp, input logic [63:0] wbase);
        check({tag, "_naw"}, 64'(aw_log.size()), 64'(exp_wa.size()));
        check({tag, "_nb"}, 64'(b_resp.size()), 64'd1);
        foreach (exp_wa[i]) begin
            if (i < aw_log.size()) begin
                check({tag, "_addr"}, 64'(aw_log[i]), 64'(exp_wa[i]));
                check({tag, "_data"}, w_log[i], wbase + 64'(i));
                check({tag, "_strb"}, 64'(ws_log[i]), 64'(8'hFF ^ 8'(i)));
            end
        end
        if (b_resp.size() > 0) begin
            check({tag, "_bresp"}, 64'(b_resp[0]), 64'(eresp));
            check({tag, "_bid"}, 64'(b_id[0]), 64'(eid));
        end
        aw_log.delete(); w_log.delete(); ws_log.delete();
        b_resp.delete(); b_id.delete(); exp_wa.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        s_if.arvalid = 1'b0; s_if.araddr = '0; s_if.arid = '0;
        s_if.arlen = '0; s_if.arburst = '0; s_if.arsize = '0;
        s_if.awvalid = 1'b0; s_if.awaddr = '0; s_if.awid = '0;
        s_if.awlen = '0; s_if.awburst = '0; s_if.awsize = '0;
        s_if.wvalid = 1'b0; s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 1'b0;
        s_if.rready = 1'b1; s_if.bready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_arready", 64'(s_if.arready), 64'd0);
        check("rst_rvalid", 64'(s_if.rvalid), 64'd0);
        check("rst_awready", 64'(s_if.awready), 64'd0);
        check("rst_wready", 64'(s_if.wready), 64'd0);
        check("rst_bvalid", 64'(s_if.bvalid), 64'd0);
        check("rst_marvalid", 64'(m_if.arvalid), 64'd0);
        check("rst_mawvalid", 64'(m_if.awvalid), 64'd0);
        rst_l = 1'b1;
        @(negedge clk);

        // INCR read, 4 beats of 8 bytes
        rd_burst(32'h1000, 1'b0, 8'd3, BURST_INCR, 3'd3, 0, 64'd0);
        exp_ra = '{32'h1000, 32'h1008, 32'h1010, 32'h1018};
        exp_rd("t1", 1'b0);

        // INCR write with OKAY then SLVERR from the slave
        br_cfg = '{RESP_OKAY, RESP_SLVERR};
        wr_burst(32'h2000, 1'b1, 8'd1, BURST_INCR, 3'd3, -1, 64'hAAAA_0000_0000_0000);
        exp_wa = '{32'h2000, 32'h2008};
        exp_wr("t2", 1'b1, RESP_SLVERR, 64'hAAAA_0000_0000_0000);

        // FIXED read with 5-cycle rready stall on the first beat
        rd_burst(32'hD058_0000, 1'b1, 8'd2, BURST_FIXED, 3'd3, 5,
                 {~32'hD058_0000, 32'hD058_0000});
        exp_ra = '{32'hD058_0000, 32'hD058_0000, 32'hD058_0000};
        exp_rd("t3", 1'b1);

        rd_burst(32'h1018, 1'b0, 8'd3, BURST_WRAP, 3'd3, 0, 64'd0);
`ifdef AXI_SPLIT_WRAP_EN
        exp_ra = '{32'h1018, 32'h1000, 32'h1008, 32'h1010};
`else
        exp_ra = '{32'h1018, 32'h1020, 32'h1028, 32'h1030};
`endif
        exp_rd("t4", 1'b0);

        // Reset in the middle of beat 2 of a 4-beat read
        s_if.arvalid = 1'b1; s_if.araddr = 32'h3000; s_if.arid = 1'b1;
        s_if.arlen = 8'd3; s_if.arburst = BURST_INCR; s_if.arsize = 3'd3;
        t = 0;
        while (!s_if.arready && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) check("t5_ar_tmo", 64'(t), 64'd0);
        @(negedge clk);
        s_if.arvalid = 1'b0;
        t = 0;
        while (!s_if.rvalid && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check("t5_r_tmo", 64'(t), 64'd0);
        @(negedge clk);
        check("t5_beat2_addr", 64'(m_if.arvalid), 64'd1);
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        check("t5_srvalid", 64'(s_if.rvalid), 64'd0);
        check("t5_marvalid", 64'(m_if.arvalid), 64'd0);
        check("t5_sarready", 64'(s_if.arready), 64'd0);
        inj_rv = 1'b1;
        @(negedge clk);
        inj_rv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t5_late_r", 64'(s_if.rvalid), 64'd0);
            @(negedge clk);
        end
        check("t5_nar", 64'(ar_log.size()), 64'd2);
        ar_log.delete();
        rd_burst(32'h3100, 1'b0, 8'd0, BURST_INCR, 3'd3, 0, 64'd0);
        exp_ra = '{32'h3100};
        exp_rd("t5_after", 1'b0);

        // Concurrent 8-beat read and write
        fork
            rd_burst(32'h4000, 1'b1, 8'd7, BURST_INCR, 3'd2, 0, 64'd0);
            wr_burst(32'h5000, 1'b0, 8'd7, BURST_INCR, 3'd3, -1, 64'h5555_0000_0000_0010);
        join
        exp_ra = '{32'h4000, 32'h4004, 32'h4008, 32'h400C,
                   32'h4010, 32'h4014, 32'h4018, 32'h401C};
        exp_rd("t6_rd", 1'b1);
        exp_wa = '{32'h5000, 32'h5008, 32'h5010, 32'h5018,
                   32'h5020, 32'h5028, 32'h5030, 32'h5038};
        exp_wr("t6_wr", 1'b0, RESP_OKAY, 64'h5555_0000_0000_0010);

        // Early wlast on beat 0 of 3
        wr_burst(32'h6000, 1'b1, 8'd2, BURST_INCR, 3'd2, 0, 64'h6666_0000_0000_0000);
        exp_wa = '{32'h6000, 32'h6004, 32'h6008};
        exp_wr("t7_early", 1'b1, RESP_SLVERR, 64'h6666_0000_0000_0000);

        // wlast missing on the final beat
        wr_burst(32'h6100, 1'b0, 8'd1, BURST_INCR, 3'd3, 1, 64'h6161_0000_0000_0000);
        exp_wa = '{32'h6100, 32'h6108};
        exp_wr("t7_nolast", 1'b0, RESP_SLVERR, 64'h6161_0000_0000_0000);

        // Single-beat write passes through with OKAY
        wr_burst(32'h6200, 1'b1, 8'd0, BURST_INCR, 3'd3, -1, 64'h6262_0000_0000_0000);
        exp_wa = '{32'h6200};
        exp_wr("t7_len0", 1'b1, RESP_OKAY, 64'h6262_0000_0000_0000);

        // 256-beat byte read crossing the top of the address space
        rd_burst(32'hFFFF_FFF0, 1'b1, 8'd255, BURST_INCR, 3'd0, 0, 64'd0);
        for (int i = 0; i < 256; i++) exp_ra.push_back(32'hFFFF_FFF0 + 32'(i));
        check("t8_lastaddr", 64'(exp_ra[255]), 64'h0000_00EF);
        exp_rd("t8", 1'b1);

`ifdef AXI_SPLIT_WRAP_EN
        rd_burst(32'h7000, 1'b0, 8'd2, BURST_WRAP, 3'd3, 0, 64'd0);
        check("t9_nar", 64'(ar_log.size()), 64'd0);
        check("t9_nbeat", 64'(r_data.size()), 64'd3);
        foreach (r_resp[i]) check("t9_resp", 64'(r_resp[i]), 64'(RESP_SLVERR));
        ar_log.delete(); r_data.delete(); r_last.delete();
        r_id.delete(); r_resp.delete();
`endif

        check("m_len_burst", 64'(ar_bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
